// File: rtl/multi_edge_detector.sv
`default_nettype none
// ============================================================================
// Module   : multi_edge_detector
// Purpose  : Per-channel synchroniser, debounce filter and mode-qualified edge
//            pulse generator. Optional sticky edge flags are built only when
//            EDGE_STICKY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module multi_edge_detector #(
    parameter int CHANNELS      = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 3
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] data,
    input  logic [1:0]          mode,
    input  logic [CHANNELS-1:0] clear,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] edge_detect,
    output logic [CHANNELS-1:0] sticky
);

    localparam logic [7:0] c_filter_limit = 8'(FILTER_CYCLES);

    genvar ch;
    generate
        for (ch = 0; ch < CHANNELS; ch++) begin : g_chan
            logic [SYNC_STAGES-1:0] sync_q;
            logic [SYNC_STAGES-1:0] sync_d;
            logic [7:0]             cnt_q;
            logic [7:0]             cnt_d;
            logic                   level_q;
            logic                   level_d;
            logic                   pulse_q;
            logic                   pulse_d;
            logic                   w_sync;

            assign w_sync = sync_q[SYNC_STAGES-1];

            // The new level is accepted only after the counter has already
            // recorded FILTER_CYCLES disagreeing samples and the next sample
            // still disagrees.
            always_comb begin
                sync_d  = {sync_q[SYNC_STAGES-2:0], data[ch]};
                cnt_d   = 8'd0;
                level_d = level_q;
                pulse_d = 1'b0;
                if (w_sync != level_q) begin
                    if (cnt_q == c_filter_limit) begin
                        level_d = w_sync;
                        pulse_d = w_sync ? mode[0] : mode[1];
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    sync_q  <= '0;
                    cnt_q   <= 8'd0;
                    level_q <= 1'b0;
                    pulse_q <= 1'b0;
                end else begin
                    sync_q  <= sync_d;
                    cnt_q   <= cnt_d;
                    level_q <= level_d;
                    pulse_q <= pulse_d;
                end
            end

            assign level[ch]       = level_q;
            assign edge_detect[ch] = pulse_q;

`ifdef EDGE_STICKY_EN
            logic sticky_q;
            logic sticky_d;

            // A pending pulse takes priority over a simultaneous clear.
            always_comb begin
                sticky_d = sticky_q;
                if (pulse_q) begin
                    sticky_d = 1'b1;
                end else if (clear[ch]) begin
                    sticky_d = 1'b0;
                end
            end

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    sticky_q <= 1'b0;
                end else begin
                    sticky_q <= sticky_d;
                end
            end

            assign sticky[ch] = sticky_q;
`else
            assign sticky[ch] = 1'b0;
`endif
        end : g_chan
    endgenerate

`ifndef EDGE_STICKY_EN
    logic w_unused_clear;
    assign w_unused_clear = ^clear;
`endif

endmodule : multi_edge_detector
`default_nettype wire

// File: tb/tb_multi_edge_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_edge_detector
// Purpose  : Directed and randomized self-checking bench for
//            multi_edge_detector against a sample-window reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_edge_detector;

    localparam int CH = 4;
    localparam int S  = 2;
    localparam int F  = 3;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [CH-1:0] data;
    logic [1:0]    mode;
    logic [CH-1:0] clear;
    logic [CH-1:0] level;
    logic [CH-1:0] edge_detect;
    logic [CH-1:0] sticky;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: raw samples still in flight plus the observable outputs.
    logic [CH-1:0] hist [$];
    logic [CH-1:0] m_level;
    logic [CH-1:0] m_edge;
    logic [CH-1:0] m_sticky;

    multi_edge_detector #(
        .CHANNELS      (CH),
        .SYNC_STAGES   (S),
        .FILTER_CYCLES (F)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .data        (data),
        .mode        (mode),
        .clear       (clear),
        .level       (level),
        .edge_detect (edge_detect),
        .sticky      (sticky)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k < S + F; k++) hist.push_back('0);
        m_level  = '0;
        m_edge   = '0;
        m_sticky = '0;
    endtask

    // A channel's level flips when the last F+1 synchronised samples (raw data
    // delayed by S edges) all disagree with the current level.
    task automatic model_step();
        logic [CH-1:0] new_edge;
        logic [CH-1:0] new_sticky;
        logic [CH-1:0] w;
        logic          all_diff;
        hist.push_back(data);
        new_edge = '0;
        for (int i = 0; i < CH; i++) begin
            all_diff = 1'b1;
            for (int k = 0; k <= F; k++) begin
                w = hist[k];
                if (w[i] == m_level[i]) all_diff = 1'b0;
            end
            if (all_diff) begin
                m_level[i]  = ~m_level[i];
                new_edge[i] = m_level[i] ? mode[0] : mode[1];
            end
        end
`ifdef EDGE_STICKY_EN
        new_sticky = m_edge | (m_sticky & ~clear);
`else
        new_sticky = '0;
`endif
        m_edge   = new_edge;
        m_sticky = new_sticky;
        void'(hist.pop_front());
    endtask

    task automatic compare_all(input string where);
        check({where, "_level"},  32'(level),       32'(m_level));
        check({where, "_edge"},   32'(edge_detect), 32'(m_edge));
        check({where, "_sticky"}, 32'(sticky),      32'(m_sticky));
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
        compare_all("cyc");
    endtask

    // Asserts reset between clock edges and releases it before the next edge.
    task automatic pulse_reset();
        #2 reset_n = 1'b0;
        #1;
        check("rst_level",  32'(level),       32'h0);
        check("rst_edge",   32'(edge_detect), 32'h0);
        check("rst_sticky", 32'(sticky),      32'h0);
        model_reset();
        #2 reset_n = 1'b1;
    endtask

    initial begin
        int cnt;
        int seen;
        logic [CH-1:0] prev_edge;

        reset_n = 1'b0;
        data    = '0;
        mode    = 2'b00;
        clear   = '0;
        model_reset();
        #12;
        check("por_level",  32'(level),       32'h0);
        check("por_edge",   32'(edge_detect), 32'h0);
        check("por_sticky", 32'(sticky),      32'h0);
        reset_n = 1'b1;

        // Latency: rise on ch0 with mode=01 lands on the sixth edge (index 5).
        mode = 2'b01;
        data = 4'b0001;
        for (int t = 0; t < 10; t++) begin
            tick();
            if (t == 4) check("lat_before", 32'(level[0]), 32'h0);
            if (t == 5) begin
                check("lat_level", 32'(level[0]),       32'h1);
                check("lat_edge",  32'(edge_detect[0]), 32'h1);
            end
            if (t == 6) check("lat_edge_once", 32'(edge_detect[0]), 32'h0);
        end

        // Glitch shorter than the filter, then a qualifying 4-cycle pulse.
        mode = 2'b11;
        data[1] = 1'b1;
        cnt = 0;
        for (int t = 0; t < 12; t++) begin
            if (t == 2) data[1] = 1'b0;
            tick();
            cnt += int'(edge_detect[1]) + int'(level[1]);
        end
        check("glitch_quiet", 32'(cnt), 32'h0);
        data[1] = 1'b1;
        cnt = 0;
        for (int t = 0; t < 20; t++) begin
            if (t == 4) data[1] = 1'b0;
            tick();
            cnt += int'(edge_detect[1]);
        end
        check("pulse4_edges", 32'(cnt), 32'h2);

        // Falling-only mode, then mode none with the same stimulus.
        for (int pass = 0; pass < 2; pass++) begin
            mode = (pass == 0) ? 2'b10 : 2'b00;
            cnt = 0;
            seen = 0;
            data[2] = 1'b1;
            for (int t = 0; t < 20; t++) begin
                if (t == 10) data[2] = 1'b0;
                tick();
                cnt += int'(edge_detect[2]);
                if (t == 9) seen = int'(level[2]);
            end
            check(pass == 0 ? "fall_only_edges" : "mode_none_edges", 32'(cnt), pass == 0 ? 32'h1 : 32'h0);
            check(pass == 0 ? "fall_only_level" : "mode_none_level", 32'(seen), 32'h1);
        end

        // All channels rise together.
        mode = 2'b01;
        data = '0;
        for (int t = 0; t < 10; t++) tick();
        data = 4'b1111;
        cnt = 0;
        for (int t = 0; t < 10; t++) begin
            tick();
            if (edge_detect == 4'b1111) cnt++;
        end
        check("all_rise_once", 32'(cnt), 32'h1);

        // Sticky: clear coincident with the pulse loses, clear alone wins.
        data = 4'b0111;
        for (int t = 0; t < 10; t++) tick();
        clear = 4'b1111;
        tick();
        tick();
        clear = '0;
        data[3] = 1'b0;
        for (int t = 0; t < 10; t++) tick();
        data[3] = 1'b1;
        seen = 0;
        for (int t = 0; t < 10 && seen == 0; t++) begin
            tick();
            if (edge_detect[3]) seen = 1;
        end
        check("ch3_pulse_seen", 32'(seen), 32'h1);
        clear[3] = 1'b1;
        tick();
`ifdef EDGE_STICKY_EN
        check("sticky_set_wins", 32'(sticky[3]), 32'h1);
`else
        check("sticky_absent", 32'(sticky[3]), 32'h0);
`endif
        tick();
        check("sticky_cleared", 32'(sticky[3]), 32'h0);
        clear = '0;

        // Reset mid-filter with levels already high elsewhere.
        data = 4'b1110;
        for (int t = 0; t < 10; t++) tick();
        data = 4'b1111;
        for (int t = 0; t < 4; t++) tick();
        pulse_reset();
        for (int t = 0; t < 8; t++) begin
            tick();
            if (t == 4) check("post_rst_before", 32'(edge_detect), 32'h0);
            if (t == 5) check("post_rst_edge",   32'(edge_detect), 32'hF);
        end

        // Randomized traffic.
        prev_edge = '0;
        for (int t = 0; t < 1500; t++) begin
            for (int i = 0; i < CH; i++)
                if ($urandom_range(0, 5) == 0) data[i] = ~data[i];
            if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
            clear = CH'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 149) == 0) begin
                pulse_reset();
                prev_edge = '0;
            end
            tick();
            check("no_back2back", 32'(edge_detect & prev_edge), 32'h0);
            prev_edge = edge_detect;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_multi_edge_detector
`default_nettype wire
